// File: rtl/paddle_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_input_ctrl
//  Description : Converts two raw, bouncy, asynchronous push-buttons into
//                single-cycle up/down move strobes for a paddle position
//                register. Each button passes through a 2-FF synchroniser
//                and a counter debouncer. A hold-to-repeat state machine then
//                issues one strobe per STEP_CYCLES while a single button is
//                held.
//  Ports       :
//      clock       in   1  system clock
//      reset       in   1  asynchronous, active-high reset
//      btn_up_raw  in   1  raw up button, asynchronous to clock
//      btn_dn_raw  in   1  raw down button, asynchronous to clock
//      enable      in   1  1: strobes allowed; 0: paused, strobes suppressed
//      up          out  1  one-cycle move-up strobe
//      down        out  1  one-cycle move-down strobe
//      held_up     out  1  debounced up level (1 = pressed)
//      held_dn     out  1  debounced down level (1 = pressed)
//  Parameters  :
//      DB_CYCLES   consecutive disagreeing samples to flip a debounced level
//      STEP_CYCLES clock cycles between repeated strobes while held
//      ACTIVE_LOW  1: raw button reads 0 when pressed
//  Revision    : 1.0 - initial release
// ============================================================================
module paddle_input_ctrl #(
    parameter logic [19:0] DB_CYCLES   = 20'd500000,
    parameter logic [19:0] STEP_CYCLES = 20'd250000,
    parameter logic        ACTIVE_LOW  = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_dn_raw,
    input  logic enable,
    output logic up,
    output logic down,
    output logic held_up,
    output logic held_dn
);

    localparam logic [19:0] c_db_last   = DB_CYCLES - 20'd1;
    localparam logic [19:0] c_step_last = STEP_CYCLES - 20'd1;

    // Index 0 = up button, index 1 = down button.
    logic [1:0] w_raw;
    logic [1:0] w_held;

    assign w_raw = {btn_dn_raw, btn_up_raw};

    // ------------------------------------------------------------------------
    // Per-button synchroniser and debouncer
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < 2; i++) begin : g_btn
            logic        r_s1;
            logic        r_s2;
            logic [19:0] r_cnt;
            logic        r_held;
            logic        w_pressed;

            // Normalise polarity so that 1 always means "pressed".
            assign w_pressed = r_s2 ^ ACTIVE_LOW;
            assign w_held[i] = r_held;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    // Sync flops come out of reset at the released level so
                    // a held button is seen as a fresh press afterwards.
                    r_s1   <= ACTIVE_LOW;
                    r_s2   <= ACTIVE_LOW;
                    r_cnt  <= 20'd0;
                    r_held <= 1'b0;
                end else begin
                    r_s1 <= w_raw[i];
                    r_s2 <= r_s1;
                    if (w_pressed == r_held) begin
                        r_cnt <= 20'd0;
                    end else if (r_cnt == c_db_last) begin
                        r_held <= ~r_held;
                        r_cnt  <= 20'd0;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
            end
        end
    endgenerate

    assign held_up = w_held[0];
    assign held_dn = w_held[1];

    // ------------------------------------------------------------------------
    // Hold-to-repeat state machine with registered strobes
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MOVE_UP = 2'd1,
        ST_MOVE_DN = 2'd2
    } state_t;

    state_t      r_state;
    logic [19:0] r_step_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_step_cnt <= 20'd0;
            up         <= 1'b0;
            down       <= 1'b0;
        end else begin
            up   <= 1'b0;
            down <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_step_cnt <= 20'd0;
                    if (enable && w_held[0] && !w_held[1]) begin
                        r_state <= ST_MOVE_UP;
                        up      <= 1'b1;
                    end else if (enable && w_held[1] && !w_held[0]) begin
                        r_state <= ST_MOVE_DN;
                        down    <= 1'b1;
                    end
                end
                ST_MOVE_UP: begin
                    // Leaving takes priority over a due repeat strobe.
                    if (!enable || !w_held[0] || w_held[1]) begin
                        r_state    <= ST_IDLE;
                        r_step_cnt <= 20'd0;
                    end else if (r_step_cnt == c_step_last) begin
                        up         <= 1'b1;
                        r_step_cnt <= 20'd0;
                    end else begin
                        r_step_cnt <= r_step_cnt + 20'd1;
                    end
                end
                ST_MOVE_DN: begin
                    if (!enable || !w_held[1] || w_held[0]) begin
                        r_state    <= ST_IDLE;
                        r_step_cnt <= 20'd0;
                    end else if (r_step_cnt == c_step_last) begin
                        down       <= 1'b1;
                        r_step_cnt <= 20'd0;
                    end else begin
                        r_step_cnt <= r_step_cnt + 20'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_step_cnt <= 20'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_paddle_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paddle_input_ctrl
//  Description : Self-checking bench for paddle_input_ctrl. Table of per-run
//                input/expected-output records plus a hand-written reset
//                mid-hold sequence; a second instance uses STEP_CYCLES=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_input_ctrl;

    logic clock;
    logic reset;
    logic btn_up_raw;
    logic btn_dn_raw;
    logic enable;
    logic up, down, held_up, held_dn;
    logic up1, down1, held_up1, held_dn1;

    int checks = 0;
    int errors = 0;

    paddle_input_ctrl #(
        .DB_CYCLES  (20'd4),
        .STEP_CYCLES(20'd8),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_up_raw(btn_up_raw),
        .btn_dn_raw(btn_dn_raw),
        .enable    (enable),
        .up        (up),
        .down      (down),
        .held_up   (held_up),
        .held_dn   (held_dn)
    );

    paddle_input_ctrl #(
        .DB_CYCLES  (20'd4),
        .STEP_CYCLES(20'd1),
        .ACTIVE_LOW (1'b1)
    ) dut_fast (
        .clock     (clock),
        .reset     (reset),
        .btn_up_raw(btn_up_raw),
        .btn_dn_raw(btn_dn_raw),
        .enable    (enable),
        .up        (up1),
        .down      (down1),
        .held_up   (held_up1),
        .held_dn   (held_dn1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One record = inputs held for n edges, expected {up,down,held_up,held_dn}
    // after each of those edges.
    typedef struct {
        logic        up_raw;
        logic        dn_raw;
        logic        en;
        int          n;
        logic [3:0]  exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic u, input logic d, input logic e,
                       input int n, input logic [3:0] x);
        vec_t v;
        v.up_raw = u; v.dn_raw = d; v.en = e; v.n = n; v.exp = x;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] got,
                         input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got {up,dn,hu,hd}=%b required %b", name, got, exp);
        end
    endtask

    initial begin
        // ---------------- table build ----------------
        // idle settle
        add(1,1,1, 3, 4'b0000);
        // clean up press held 40 cycles: held at 6, strobes 7,15,23,31,39
        add(0,1,1, 5, 4'b0000);
        add(0,1,1, 1, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            add(0,1,1, 1, 4'b1010);
            add(0,1,1, 7, 4'b0010);
        end
        add(0,1,1, 1, 4'b1010);
        add(0,1,1, 1, 4'b0010);
        add(1,1,1, 5, 4'b0010);
        add(1,1,1, 3, 4'b0000);
        // 3-cycle down glitch: rejected
        add(1,0,1, 3, 4'b0000);
        add(1,1,1, 6, 4'b0000);
        // both pressed together: both held, never a strobe
        add(0,0,1, 5, 4'b0000);
        add(0,0,1,11, 4'b0011);
        add(1,1,1, 5, 4'b0011);
        add(1,1,1, 3, 4'b0000);
        // up held, then down also pressed, then down released
        add(0,1,1, 5, 4'b0000);
        add(0,1,1, 1, 4'b0010);
        add(0,1,1, 1, 4'b1010);
        add(0,1,1, 7, 4'b0010);
        add(0,1,1, 1, 4'b1010);
        add(0,1,1, 1, 4'b0010);
        add(0,0,1, 5, 4'b0010);
        add(0,0,1, 9, 4'b0011);   // edge 23 strobe suppressed by held_dn
        add(0,1,1, 5, 4'b0011);
        add(0,1,1, 1, 4'b0010);
        add(0,1,1, 1, 4'b1010);   // re-entry one edge after held_dn falls
        add(0,1,1, 7, 4'b0010);
        add(0,1,1, 1, 4'b1010);
        add(1,1,1, 5, 4'b0010);
        add(1,1,1, 3, 4'b0000);
        // down held, enable dropped, then restored
        add(1,0,1, 5, 4'b0000);
        add(1,0,1, 1, 4'b0001);
        add(1,0,1, 1, 4'b0101);
        add(1,0,1, 7, 4'b0001);
        add(1,0,1, 1, 4'b0101);
        add(1,0,1, 1, 4'b0001);
        add(1,0,0, 9, 4'b0001);
        add(1,0,1, 1, 4'b0101);
        add(1,0,1, 7, 4'b0001);
        add(1,0,1, 1, 4'b0101);
        add(1,1,1, 5, 4'b0001);
        add(1,1,1, 3, 4'b0000);

        // ---------------- reset state ----------------
        btn_up_raw = 1'b1;
        btn_dn_raw = 1'b1;
        enable     = 1'b1;
        reset      = 1'b1;
        #2;
        check("reset_async", {up, down, held_up, held_dn}, 4'b0000);
        @(posedge clock); #1;
        check("reset_held", {up, down, held_up, held_dn}, 4'b0000);
        reset = 1'b0;

        // ---------------- table run ----------------
        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                btn_up_raw = vecs[i].up_raw;
                btn_dn_raw = vecs[i].dn_raw;
                enable     = vecs[i].en;
                @(posedge clock); #1;
                check($sformatf("vec%0d_cyc%0d", i, c),
                      {up, down, held_up, held_dn}, vecs[i].exp);
            end
        end

        // ---------------- reset asserted mid-hold ----------------
        btn_up_raw = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("midhold_reset_async", {up, down, held_up, held_dn}, 4'b0000);
        check("midhold_reset_async_fast", {up1, down1, held_up1, held_dn1}, 4'b0000);
        @(posedge clock); #1;
        check("midhold_reset_edge", {up, down, held_up, held_dn}, 4'b0000);
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clock); #1;
            check($sformatf("after_reset_edge%0d", e),
                  {up, down, held_up, held_dn},
                  {(e == 7), 1'b0, (e >= 6), 1'b0});
            // STEP_CYCLES=1: strobe on every edge once moving
            check($sformatf("fast_edge%0d", e),
                  {up1, down1, held_up1, held_dn1},
                  {(e >= 7), 1'b0, (e >= 6), 1'b0});
        end
        btn_up_raw = 1'b1;
        repeat (8) @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
